// File: rtl/lab_pkg.sv
// Shared definitions for the lab checkers: sweep FSM encoding and parameter legality checks.
package lab_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_FINISH = 2'd2
    } sweep_state_e;

    function automatic bit width_ok(input int w);
        return (w >= 2) && (w <= 16) && ((w % 2) == 0);
    endfunction

    function automatic bit settle_ok(input int s);
        return s >= 1;
    endfunction

endpackage

// File: rtl/lab02_golden.sv
// Golden NOR/NAND/AND lab function: high only when the upper half is all zero
// and the lower half is not all ones. Purely combinational.
module lab02_golden #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic             exp
);

    localparam int HALF = WIDTH / 2;

    assign exp = ~|vec[WIDTH-1:HALF] & ~&vec[HALF-1:0];

endmodule

// File: rtl/lab02_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every vector to an external DUT, compares the
// response after SETTLE cycles against the golden function and reports pass/fail.
module lab02_sweep_checker
    import lab_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] stim,
    output logic             stim_valid,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             first_fail_valid
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] VEC_LAST = '1;

    generate
        if (!width_ok(WIDTH) || !settle_ok(SETTLE)) begin : g_param_check
            $error("lab02_sweep_checker: illegal WIDTH/SETTLE");
        end
    endgenerate

    sweep_state_e     state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             pass_q, pass_d;
    logic             sv_q, sv_d;
    logic             done_q, done_d;
    logic             gold_exp;
    logic             mismatch;

    lab02_golden #(.WIDTH(WIDTH)) u_golden (
        .vec (vec_q),
        .exp (gold_exp)
    );

    assign mismatch = dut_y ^ gold_exp;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                // Abort wins over a compare landing in the same cycle.
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (mismatch) begin
                            err_d = err_q + {{WIDTH{1'b0}}, 1'b1};
                            if (!ffv_q) begin
                                ff_d  = vec_q;
                                ffv_d = 1'b1;
                            end
                        end
                        if (vec_q == VEC_LAST) begin
                            state_d = S_FINISH;
                            vec_d   = '0;
                            pass_d  = (err_q == '0) && !mismatch;
                        end else begin
                            vec_d = vec_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so every output comes from a flop.
    assign sv_d   = (state_d == S_APPLY);
    assign done_d = (state_d == S_FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            sv_q    <= sv_d;
            done_q  <= done_d;
        end
    end

    assign stim             = vec_q;
    assign stim_valid       = sv_q;
    assign busy             = sv_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_lab02_sweep_checker.sv
// Bench for lab02_sweep_checker: a 4-bit/SETTLE=1 instance with selectable faulty DUTs and a
// 6-bit/SETTLE=3 instance behind a two-stage registered DUT, both tracked by a timeline model.
module tb_lab02_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic drv_start[2];
    logic drv_abort[2];
    int   mode4;

    logic [3:0] stim4;  logic sv4, busy4, done4, pass4, ffv4, y4;
    logic [4:0] err4;   logic [3:0] ff4;
    logic [5:0] stim6;  logic sv6, busy6, done6, pass6, ffv6, y6;
    logic [6:0] err6;   logic [5:0] ff6;
    logic r1 = 1'b0, r2 = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    function automatic bit gold(input int v, input int w);
        int h  = w / 2;
        int lm = (1 << h) - 1;
        return ((v >> h) == 0) && ((v & lm) != lm);
    endfunction

    lab02_sweep_checker #(.WIDTH(4), .SETTLE(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(drv_start[0]), .abort(drv_abort[0]),
        .stim(stim4), .stim_valid(sv4), .dut_y(y4), .busy(busy4), .done(done4),
        .pass(pass4), .err_count(err4), .first_fail(ff4), .first_fail_valid(ffv4)
    );

    lab02_sweep_checker #(.WIDTH(6), .SETTLE(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(drv_start[1]), .abort(drv_abort[1]),
        .stim(stim6), .stim_valid(sv6), .dut_y(y6), .busy(busy6), .done(done6),
        .pass(pass6), .err_count(err6), .first_fail(ff6), .first_fail_valid(ffv6)
    );

    // Lab DUT stand-ins: 0 correct, 1 stuck-at-0, 2 inverted, 3 stuck-at-1.
    always_comb begin
        case (mode4)
            1:       y4 = 1'b0;
            2:       y4 = !gold(int'(stim4), 4);
            3:       y4 = 1'b1;
            default: y4 = gold(int'(stim4), 4);
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= gold(int'(stim6), 6);
            r2 <= r1;
        end
    end
    assign y6 = r2;

    int o_stim[2], o_err[2], o_ff[2];
    logic o_sv[2], o_busy[2], o_done[2], o_pass[2], o_ffv[2], i_y[2];
    always_comb begin
        o_stim[0] = int'(stim4); o_sv[0] = sv4; o_busy[0] = busy4; o_done[0] = done4;
        o_pass[0] = pass4; o_err[0] = int'(err4); o_ff[0] = int'(ff4); o_ffv[0] = ffv4;
        o_stim[1] = int'(stim6); o_sv[1] = sv6; o_busy[1] = busy6; o_done[1] = done6;
        o_pass[1] = pass6; o_err[1] = int'(err6); o_ff[1] = int'(ff6); o_ffv[1] = ffv6;
        i_y[0] = y4;
        i_y[1] = y6;
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Model: m_t is the cycle index since the accepted start (0 = idle,
    // 1..2^W*S = applying, 2^W*S+1 = done cycle).
    int cw[2] = '{4, 6};
    int cs[2] = '{1, 3};
    int m_t[2], m_err[2], m_ff[2];
    bit m_ffv[2], m_pass[2];

    task automatic model_cycle(input int k);
        int  ns = (1 << cw[k]) * cs[k];
        bit  act;
        int  e_stim, v;
        bit  e_done;
        if (!rst_n) begin
            m_t[k] = 0; m_err[k] = 0; m_ff[k] = 0; m_ffv[k] = 0; m_pass[k] = 0;
        end
        act    = (m_t[k] >= 1) && (m_t[k] <= ns);
        e_stim = act ? (m_t[k] - 1) / cs[k] : 0;
        e_done = (m_t[k] == ns + 1);
        n_chk++;
        if (o_stim[k] == e_stim && o_sv[k] == act && o_busy[k] == act && o_done[k] == e_done &&
            o_pass[k] == m_pass[k] && o_err[k] == m_err[k] && o_ff[k] == m_ff[k] &&
            o_ffv[k] == m_ffv[k]) begin
            n_pass++;
        end else begin
            $display("FAIL cycle_model dut%0d t=%0d got stim=%0d vld=%b busy=%b done=%b pass=%b err=%0d ff=%0d ffv=%b expected stim=%0d vld=%b busy=%b done=%b pass=%b err=%0d ff=%0d ffv=%b",
                     cw[k], m_t[k], o_stim[k], o_sv[k], o_busy[k], o_done[k], o_pass[k],
                     o_err[k], o_ff[k], o_ffv[k], e_stim, act, act, e_done, m_pass[k],
                     m_err[k], m_ff[k], m_ffv[k]);
        end
        if (!rst_n) return;
        if (m_t[k] == 0) begin
            if (drv_start[k]) begin
                m_t[k] = 1; m_err[k] = 0; m_ff[k] = 0; m_ffv[k] = 0; m_pass[k] = 0;
            end
        end else if (m_t[k] <= ns) begin
            if (drv_abort[k]) begin
                m_t[k] = 0;
                m_pass[k] = 0;
            end else begin
                v = (m_t[k] - 1) / cs[k];
                if (((m_t[k] - 1) % cs[k]) == cs[k] - 1 && i_y[k] != gold(v, cw[k])) begin
                    m_err[k]++;
                    if (!m_ffv[k]) begin
                        m_ff[k] = v;
                        m_ffv[k] = 1;
                    end
                end
                m_t[k]++;
                if (m_t[k] == ns + 1) m_pass[k] = (m_err[k] == 0);
            end
        end else begin
            m_t[k] = 0;
        end
    endtask

    initial begin
        m_t = '{0, 0}; m_err = '{0, 0}; m_ff = '{0, 0}; m_ffv = '{0, 0}; m_pass = '{0, 0};
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_cycle(k);
    end

    int done_cyc, c1_err, c1_ffv, s_at1, s_at16, runs, bad_runs;

    // Runs one sweep on instance k; n counts cycles after the edge that samples start.
    task automatic sweep(input int k, input int restart_at, input int abort_at, input int rst_at);
        int run = 0, prev = -1;
        done_cyc = 0; runs = 0; bad_runs = 0;
        @(posedge clk); #2;
        drv_start[k] = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #2;
            drv_start[k] = (n == restart_at);
            drv_abort[k] = (n == abort_at);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs",
                    int'({stim4, sv4, busy4, done4, pass4, err4, ff4, ffv4}), 0);
                break;
            end
            @(negedge clk);
            if (n == 1) begin
                c1_err = o_err[k]; c1_ffv = int'(o_ffv[k]); s_at1 = o_stim[k];
            end
            if (n == 16) s_at16 = o_stim[k];
            if (o_sv[k]) begin
                if (run > 0 && o_stim[k] != prev) begin
                    if (run != cs[k]) bad_runs++;
                    runs++;
                    run = 0;
                end
                prev = o_stim[k];
                run++;
            end else if (run > 0) begin
                if (run != cs[k]) bad_runs++;
                runs++;
                run = 0;
            end
            if (abort_at > 0 && n == abort_at + 1) begin
                chk("abort_busy_next", int'(o_busy[k]), 0);
                chk("abort_valid_next", int'(o_sv[k]), 0);
            end
            if (o_done[k]) begin
                done_cyc = n;
                break;
            end
            if (abort_at > 0 && n == abort_at + 5) break;
        end
        drv_start[k] = 1'b0;
        drv_abort[k] = 1'b0;
    endtask

    initial begin
        drv_start = '{1'b0, 1'b0};
        drv_abort = '{1'b0, 1'b0};
        mode4 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_dut4", int'({stim4, sv4, busy4, done4, pass4, err4, ff4, ffv4}), 0);
        chk("reset_dut6", int'({stim6, sv6, busy6, done6, pass6, err6, ff6, ffv6}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Correct DUT, with a start pulse in cycle 5 that must be ignored.
        mode4 = 0;
        sweep(0, 5, 0, 0);
        chk("good_done_cycle", done_cyc, 17);
        chk("good_pass", int'(pass4), 1);
        chk("good_err", int'(err4), 0);
        chk("good_ffv", int'(ffv4), 0);
        chk("good_stim_cycle1", s_at1, 0);
        chk("good_stim_cycle16", s_at16, 15);

        mode4 = 1;
        sweep(0, 0, 0, 0);
        chk("stuck0_err", int'(err4), 3);
        chk("stuck0_first_fail", int'(ff4), 0);
        chk("stuck0_ffv", int'(ffv4), 1);
        chk("stuck0_pass", int'(pass4), 0);

        mode4 = 2;
        sweep(0, 0, 0, 0);
        chk("inv_err", int'(err4), 16);
        chk("inv_first_fail", int'(ff4), 0);

        mode4 = 3;
        sweep(0, 0, 0, 0);
        chk("stuck1_err", int'(err4), 13);
        chk("stuck1_first_fail", int'(ff4), 3);
        chk("stuck1_done_cycle", done_cyc, 17);

        // A fresh start clears the previous sweep's results in its first APPLY cycle.
        mode4 = 0;
        sweep(0, 0, 0, 0);
        chk("restart_err_cycle1", c1_err, 0);
        chk("restart_ffv_cycle1", c1_ffv, 0);
        chk("restart_pass", int'(pass4), 1);

        sweep(1, 0, 0, 0);
        chk("w6_done_cycle", done_cyc, 193);
        chk("w6_pass", int'(pass6), 1);
        chk("w6_hold_runs", runs, 64);
        chk("w6_bad_hold_runs", bad_runs, 0);

        // Inverted DUT aborted while stim=5: vectors 0..4 fail, the compare on 5 is dropped.
        mode4 = 2;
        sweep(0, 0, 6, 0);
        chk("abort_no_done", done_cyc, 0);
        chk("abort_err", int'(err4), 5);
        chk("abort_first_fail", int'(ff4), 0);
        chk("abort_ffv", int'(ffv4), 1);
        chk("abort_pass", int'(pass4), 0);

        mode4 = 0;
        sweep(0, 0, 0, 8);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("post_reset_idle", int'({busy4, sv4, done4}), 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
